// File: rtl/vram_sram_model_if.sv
// Pin bundle between the VRAM interface (master) and the external video SRAM model (slave).
interface vram_sram_model_if;
  logic [12:0] ma;
  logic [7:0]  md_in;
  logic        nmcs;
  logic        nmoe;
  logic        nmwr;
  logic [7:0]  md_out;
  logic        md_oe;
  logic        wr_commit;
  logic        err_overlap;
  logic        err_short_wr;
  logic        err_addr_wr;

  modport master (
    output ma, md_in, nmcs, nmoe, nmwr,
    input  md_out, md_oe, wr_commit, err_overlap, err_short_wr, err_addr_wr
  );

  modport slave (
    input  ma, md_in, nmcs, nmoe, nmwr,
    output md_out, md_oe, wr_commit, err_overlap, err_short_wr, err_addr_wr
  );
endinterface

// File: rtl/vram_sram_model.sv
// Behavioural 8 KiB video SRAM responder with programmable access/hold/write-pulse timing.
// Define VRAM_SRAM_CHECK_EN to build the sticky bus-protocol error flags.
module vram_sram_model #(
  parameter int unsigned T_ACC = 2,
  parameter int unsigned T_OH  = 1,
  parameter int unsigned T_WP  = 2
) (
  input  logic             clk,
  input  logic             nreset,
  vram_sram_model_if.slave bus
);
  localparam logic [3:0] ACC_CNT = 4'(T_ACC);
  localparam logic [3:0] OH_LAST = 4'((T_OH == 0) ? 0 : T_OH - 1);
  localparam logic [3:0] WP_CNT  = 4'(T_WP);
  localparam bit         OH_NONE = (T_OH == 0);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, RD_HOLD, WR_ACT} state_t;

  logic [7:0]  mem [0:8191];

  logic [12:0] ma_s;
  logic [7:0]  md_s;
  logic        cs, oe, wr;
  logic        rd_req, wr_req;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [12:0] ra_reg, ra_next;
  logic [12:0] wa_reg, wa_next;
  logic [7:0]  wd_reg, wd_next;
  logic        md_oe_reg, md_oe_next;
  logic [7:0]  md_out_reg;
  logic        wr_commit_reg, wr_commit_next;
  logic        md_load, mem_we, go_wr, go_rd;

  // Single sampling stage, strobes converted to active-high.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ma_s <= '0;
      md_s <= '0;
      cs   <= 1'b0;
      oe   <= 1'b0;
      wr   <= 1'b0;
    end else begin
      ma_s <= bus.ma;
      md_s <= bus.md_in;
      cs   <= ~bus.nmcs;
      oe   <= ~bus.nmoe;
      wr   <= ~bus.nmwr;
    end
  end

  assign rd_req = cs & oe & ~wr;
  assign wr_req = cs & wr;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ra_next        = ra_reg;
    wa_next        = wa_reg;
    wd_next        = wd_reg;
    md_oe_next     = md_oe_reg;
    wr_commit_next = 1'b0;
    md_load        = 1'b0;
    mem_we         = 1'b0;
    go_wr          = 1'b0;
    go_rd          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_req)      go_wr = 1'b1;
        else if (rd_req) go_rd = 1'b1;
      end
      RD_WAIT: begin
        if (wr_req)               go_wr = 1'b1;
        else if (!rd_req)         state_next = IDLE;
        else if (ma_s != ra_reg)  go_rd = 1'b1;
        else if (cnt_reg == ACC_CNT) begin
          state_next = RD_DRIVE;
          md_oe_next = 1'b1;
          md_load    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RD_DRIVE: begin
        if (wr_req) begin
          go_wr = 1'b1;
        end else if (!rd_req) begin
          if (OH_NONE) begin
            state_next = IDLE;
            md_oe_next = 1'b0;
          end else begin
            state_next = RD_HOLD;
            cnt_next   = 4'd0;
          end
        end else if (ma_s != ra_reg) begin
          go_rd = 1'b1;
        end else begin
          md_load = 1'b1;
        end
      end
      RD_HOLD: begin
        if (wr_req)      go_wr = 1'b1;
        else if (rd_req) go_rd = 1'b1;
        else if (cnt_reg == OH_LAST) begin
          state_next = IDLE;
          md_oe_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      WR_ACT: begin
        if (wr_req) begin
          wd_next = md_s;
          if (cnt_reg != 4'hF) cnt_next = cnt_reg + 4'd1;
        end else begin
          state_next = IDLE;
          if (cnt_reg >= WP_CNT) begin
            mem_we         = 1'b1;
            wr_commit_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Entry actions shared by every path into a write or a (re)started read.
    if (go_wr) begin
      state_next = WR_ACT;
      cnt_next   = 4'd1;
      wa_next    = ma_s;
      wd_next    = md_s;
      md_oe_next = 1'b0;
    end else if (go_rd) begin
      state_next = RD_WAIT;
      cnt_next   = 4'd1;
      ra_next    = ma_s;
      md_oe_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      ra_reg        <= '0;
      wa_reg        <= '0;
      wd_reg        <= '0;
      md_oe_reg     <= 1'b0;
      md_out_reg    <= '0;
      wr_commit_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ra_reg        <= ra_next;
      wa_reg        <= wa_next;
      wd_reg        <= wd_next;
      md_oe_reg     <= md_oe_next;
      wr_commit_reg <= wr_commit_next;
      if (md_load) md_out_reg <= mem[ra_reg];
    end
  end

  // Storage is never cleared; a reset forces IDLE so an in-flight write cannot land.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wa_reg] <= wd_reg;
  end

  assign bus.md_out    = md_out_reg;
  assign bus.md_oe     = md_oe_reg;
  assign bus.wr_commit = wr_commit_reg;

`ifdef VRAM_SRAM_CHECK_EN
  logic err_overlap_reg, err_short_wr_reg, err_addr_wr_reg;
  logic short_wr, addr_moved;

  assign short_wr   = (state_reg == WR_ACT) && !wr_req && (cnt_reg < WP_CNT);
  assign addr_moved = (state_reg == WR_ACT) && wr_req && (ma_s != wa_reg);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_overlap_reg  <= 1'b0;
      err_short_wr_reg <= 1'b0;
      err_addr_wr_reg  <= 1'b0;
    end else begin
      if (cs & oe & wr) err_overlap_reg  <= 1'b1;
      if (short_wr)     err_short_wr_reg <= 1'b1;
      if (addr_moved)   err_addr_wr_reg  <= 1'b1;
    end
  end

  assign bus.err_overlap  = err_overlap_reg;
  assign bus.err_short_wr = err_short_wr_reg;
  assign bus.err_addr_wr  = err_addr_wr_reg;
`else
  assign bus.err_overlap  = 1'b0;
  assign bus.err_short_wr = 1'b0;
  assign bus.err_addr_wr  = 1'b0;
`endif
endmodule

// File: tb/tb_vram_sram_model.sv
// Directed bench for vram_sram_model: writes, reads, hold timing, protocol flags, reset mid-write.
module tb_vram_sram_model;
  logic clk = 1'b0;
  logic nreset;
  int   checks = 0;
  int   errors = 0;

`ifdef VRAM_SRAM_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  vram_sram_model_if bus ();
  vram_sram_model_if bus_oh0 ();

  vram_sram_model #(.T_ACC(2), .T_OH(1), .T_WP(2)) u_dut (
    .clk(clk), .nreset(nreset), .bus(bus.slave)
  );
  vram_sram_model #(.T_ACC(2), .T_OH(0), .T_WP(2)) u_dut_oh0 (
    .clk(clk), .nreset(nreset), .bus(bus_oh0.slave)
  );

  assign bus_oh0.ma    = bus.ma;
  assign bus_oh0.md_in = bus.md_in;
  assign bus_oh0.nmcs  = bus.nmcs;
  assign bus_oh0.nmoe  = bus.nmoe;
  assign bus_oh0.nmwr  = bus.nmwr;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cycle(input logic [12:0] addr, input logic [7:0] data, input int k,
                             input logic with_oe, input logic exp_commit);
    bus.ma = addr; bus.md_in = data;
    bus.nmcs = 1'b0; bus.nmwr = 1'b0; bus.nmoe = ~with_oe;
    repeat (k) tick();
    bus.nmcs = 1'b1; bus.nmwr = 1'b1; bus.nmoe = 1'b1;
    tick();
    check("wr_commit_early", 8'(bus.wr_commit), 8'(1'b0));
    tick();
    check("wr_commit", 8'(bus.wr_commit), 8'(exp_commit));
    check("wr_md_oe", 8'(bus.md_oe), 8'(1'b0));
    tick();
    check("wr_commit_end", 8'(bus.wr_commit), 8'(1'b0));
  endtask

  task automatic read_cycle(input logic [12:0] addr, input logic [7:0] exp);
    bus.ma = addr; bus.nmcs = 1'b0; bus.nmoe = 1'b0;
    repeat (3) tick();
    check("rd_oe_early", 8'(bus.md_oe), 8'(1'b0));
    tick();
    check("rd_oe", 8'(bus.md_oe), 8'(1'b1));
    check("rd_data", bus.md_out, exp);
    check("rd_data_oh0", bus_oh0.md_out, exp);
    bus.nmcs = 1'b1; bus.nmoe = 1'b1;
    tick();
    check("rel_oe_sample", 8'(bus.md_oe), 8'(1'b1));
    tick();
    check("rel_oe_hold", 8'(bus.md_oe), 8'(1'b1));
    check("rel_oe_oh0", 8'(bus_oh0.md_oe), 8'(1'b0));
    tick();
    check("rel_oe_off", 8'(bus.md_oe), 8'(1'b0));
    check("rel_data_frozen", bus.md_out, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_md_out"}, bus.md_out, 8'h00);
    check({tag, "_md_oe"}, 8'(bus.md_oe), 8'(1'b0));
    check({tag, "_wr_commit"}, 8'(bus.wr_commit), 8'(1'b0));
    check({tag, "_err_overlap"}, 8'(bus.err_overlap), 8'(1'b0));
    check({tag, "_err_short"}, 8'(bus.err_short_wr), 8'(1'b0));
    check({tag, "_err_addr"}, 8'(bus.err_addr_wr), 8'(1'b0));
  endtask

  initial begin
    nreset = 1'b0;
    bus.ma = '0; bus.md_in = '0;
    bus.nmcs = 1'b1; bus.nmoe = 1'b1; bus.nmwr = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    nreset = 1'b1;
    tick();

    // Basic write then read-back
    write_cycle(13'h1234, 8'hA5, 3, 1'b0, 1'b1);
    read_cycle(13'h1234, 8'hA5);

    // Minimum-width write commits; one-cycle write is dropped
    write_cycle(13'h0000, 8'h11, 2, 1'b0, 1'b1);
    check("err_short_before", 8'(bus.err_short_wr), 8'(1'b0));
    write_cycle(13'h0000, 8'h3C, 1, 1'b0, 1'b0);
    check("err_short_after", 8'(bus.err_short_wr), 8'(CHK));
    read_cycle(13'h0000, 8'h11);

    // Address change while driving restarts the access
    write_cycle(13'h0100, 8'h22, 3, 1'b0, 1'b1);
    write_cycle(13'h0101, 8'h33, 3, 1'b0, 1'b1);
    bus.ma = 13'h0100; bus.nmcs = 1'b0; bus.nmoe = 1'b0;
    repeat (4) tick();
    check("mv_oe_first", 8'(bus.md_oe), 8'(1'b1));
    check("mv_data_first", bus.md_out, 8'h22);
    bus.ma = 13'h0101;
    tick();
    check("mv_oe_still", 8'(bus.md_oe), 8'(1'b1));
    tick();
    check("mv_oe_drop", 8'(bus.md_oe), 8'(1'b0));
    tick();
    check("mv_oe_wait", 8'(bus.md_oe), 8'(1'b0));
    tick();
    check("mv_oe_again", 8'(bus.md_oe), 8'(1'b1));
    check("mv_data_second", bus.md_out, 8'h33);
    bus.nmcs = 1'b1; bus.nmoe = 1'b1;
    repeat (3) tick();
    check("mv_released", 8'(bus.md_oe), 8'(1'b0));

    // OE asserted during a write: write wins, overlap flagged
    check("err_overlap_before", 8'(bus.err_overlap), 8'(1'b0));
    write_cycle(13'h1FFF, 8'h5A, 3, 1'b1, 1'b1);
    check("err_overlap_after", 8'(bus.err_overlap), 8'(CHK));
    read_cycle(13'h1FFF, 8'h5A);

    // Address moves mid-strobe: flagged, write still lands on the first address
    check("err_addr_before", 8'(bus.err_addr_wr), 8'(1'b0));
    bus.ma = 13'h0200; bus.md_in = 8'h44;
    bus.nmcs = 1'b0; bus.nmwr = 1'b0;
    tick();
    bus.ma = 13'h0201;
    repeat (2) tick();
    bus.nmcs = 1'b1; bus.nmwr = 1'b1;
    repeat (2) tick();
    check("addr_wr_commit", 8'(bus.wr_commit), 8'(1'b1));
    tick();
    check("err_addr_after", 8'(bus.err_addr_wr), 8'(CHK));
    read_cycle(13'h0200, 8'h44);

    // Reset in the middle of a long write
    bus.ma = 13'h1234; bus.md_in = 8'h77;
    bus.nmcs = 1'b0; bus.nmwr = 1'b0;
    repeat (3) tick();
    nreset = 1'b0;
    #1;
    check_reset_outputs("midwr");
    bus.nmcs = 1'b1; bus.nmwr = 1'b1;
    repeat (2) tick();
    nreset = 1'b1;
    repeat (3) tick();
    check("midwr_no_commit", 8'(bus.wr_commit), 8'(1'b0));
    read_cycle(13'h1234, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
